// File: rtl/cfg_pkg.sv
// Shared constants and FSM encoding for the camera configuration sequencer.
package cfg_pkg;

  localparam logic [15:0] CFG_DELAY        = 16'hFF_F0;
  localparam logic [7:0]  CFG_END_REG      = 8'hFF;
  localparam logic [15:0] CFG_UNUSED       = 16'hFF_FF;
  localparam int unsigned CFG_DELAY_CYCLES = 25000;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StSend,
    StDelay,
    StDone
  } cfg_state_e;

endpackage

// File: rtl/cfg_rom_multi.sv
// Multi-profile register table ROM; one registered cycle of read latency, no reset on data.
module cfg_rom_multi
  import cfg_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned PROF_W = 1
) (
  input  logic              i_clk,
  input  logic [PROF_W-1:0] i_profile,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       o_data
);

  logic [15:0] entry;
  logic [15:0] data_q;

  always_comb begin
    entry = CFG_UNUSED;
    if (i_profile == PROF_W'(0)) begin
      // RGB444 VGA
      case (int'(i_addr))
        0:       entry = 16'h12_80;
        1:       entry = CFG_DELAY;
        2:       entry = 16'h12_04;
        3:       entry = 16'h8C_02;
        4:       entry = 16'h40_D0;
        5:       entry = 16'h3A_04;
        6:       entry = 16'h11_01;
        7:       entry = 16'hFF_FF;
        default: ;
      endcase
    end else if (i_profile == PROF_W'(1)) begin
      // RGB565 VGA
      case (int'(i_addr))
        0:       entry = 16'h12_80;
        1:       entry = CFG_DELAY;
        2:       entry = 16'h12_04;
        3:       entry = 16'h8C_00;
        4:       entry = 16'h40_D0;
        5:       entry = 16'h3A_04;
        6:       entry = 16'hFF_FF;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    data_q <= entry;
  end

  assign o_data = data_q;

endmodule

// File: rtl/cfg_seq.sv
// Configuration sequencer: walks the selected register table and emits writes over valid/ready,
// handling delay and end markers locally.
module cfg_seq
  import cfg_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned NUM_PROFILES = 2,
  parameter int unsigned PROF_W       = 1,
  parameter int unsigned DELAY_CYCLES = CFG_DELAY_CYCLES
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [PROF_W-1:0] i_profile,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [7:0]        o_wr_reg,
  output logic [7:0]        o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CntW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  cfg_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PROF_W-1:0] prof_q, prof_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              advance;
  logic [15:0]       rom_data;

  cfg_rom_multi #(
    .ADDR_W (ADDR_W),
    .PROF_W (PROF_W)
  ) u_rom (
    .i_clk     (i_clk),
    .i_profile (prof_q),
    .i_addr    (addr_q),
    .o_data    (rom_data)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    prof_d  = prof_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    err_d   = err_q;
    advance = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          prof_d = i_profile;
          addr_d = '0;
          if (32'(i_profile) >= NUM_PROFILES) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StFetch;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_data == CFG_DELAY) begin
          cnt_d   = CntW'(DELAY_CYCLES - 1);
          state_d = StDelay;
        end else if (rom_data[15:8] == CFG_END_REG) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          reg_d   = rom_data[15:8];
          wdata_d = rom_data[7:0];
          valid_d = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (i_wr_ready) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      StDelay: begin
        if (cnt_q == '0) advance = 1'b1;
        else             cnt_d = cnt_q - CntW'(1);
      end
      default: state_d = StIdle;
    endcase

    // Running off the end of the table without an end marker is an error.
    if (advance) begin
      if (addr_q == '1) begin
        state_d = StDone;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StFetch;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= StIdle;
      addr_q  <= '0;
      prof_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      prof_q  <= prof_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_wr_valid = valid_q;
  assign o_wr_reg   = reg_q;
  assign o_wr_data  = wdata_q;
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q == StFetch) || (state_q == StDecode) ||
                      (state_q == StSend)  || (state_q == StDelay);

endmodule

// File: tb/tb_cfg_seq.sv
// Self-checking bench for cfg_seq: table-level reference model, random backpressure and stimulus.
module tb_cfg_seq;

  localparam int unsigned DLY = 10;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [1:0] profile;
  logic       ready;
  logic       o_wr_valid;
  logic [7:0] o_wr_reg;
  logic [7:0] o_wr_data;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          hs_q[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_word  = '0;

  // Reference tables as the camera profiles define them.
  localparam logic [15:0] P0 [8] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h8C02,
                                     16'h40D0, 16'h3A04, 16'h1101, 16'hFFFF};
  localparam logic [15:0] P1 [8] = '{16'h1280, 16'hFFF0, 16'h1204, 16'h8C00,
                                     16'h40D0, 16'h3A04, 16'hFFFF, 16'hFFFF};

  cfg_seq #(
    .ADDR_W       (8),
    .NUM_PROFILES (2),
    .PROF_W       (2),
    .DELAY_CYCLES (DLY)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_profile  (profile),
    .o_wr_valid (o_wr_valid),
    .i_wr_ready (ready),
    .o_wr_reg   (o_wr_reg),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tbl(input int p, input int i);
    if (i >= 8) return 16'hFFFF;
    return (p == 0) ? P0[i] : P1[i];
  endfunction

  // Expected write list: every entry up to the first end marker, delay markers skipped.
  task automatic build_exp(input int p);
    logic [15:0] e;
    exp_q.delete();
    if (p >= 2) return;
    for (int i = 0; i < 256; i++) begin
      e = tbl(p, i);
      if (e == 16'hFFF0) continue;
      if (e[15:8] == 8'hFF) break;
      exp_q.push_back(e);
    end
  endtask

  // Handshake monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {15'd0, o_wr_valid, o_wr_reg, o_wr_data},
                          {15'd0, 1'b1, prev_word});
      prev_stall = o_wr_valid && !ready;
      prev_word  = {o_wr_reg, o_wr_data};
      if (o_wr_valid && ready) begin
        got_q.push_back({o_wr_reg, o_wr_data});
        hs_q.push_back(cyc);
      end
    end
  end

  // mode 0: ready high; 1: ready low 5 cycles per write; 2: random ready.
  task automatic run_seq(input int mode, input logic [1:0] prof, input bit toggle, input bit extra);
    int n;
    int held;
    got_q.delete();
    hs_q.delete();
    build_exp(int'(prof));
    @(posedge clk); #1;
    start = 1'b1;
    profile = prof;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, o_busy}, {31'd0, (prof < 2'd2)});
    n = 0;
    held = 0;
    while (!o_done && n < 3000) begin
      if (extra) start = (n % 4 == 1);
      if (toggle) profile = 2'($urandom_range(0, 1));
      case (mode)
        0: ready = 1'b1;
        1: begin
          if (o_wr_valid) begin
            held++;
            ready = (held > 5);
            if (ready) held = 0;
          end else begin
            ready = 1'($urandom_range(0, 1));
          end
        end
        default: ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    ready = 1'b0;
    chk("run_done", {31'd0, o_done}, 32'd1);
  endtask

  task automatic compare_writes(input bit exp_err);
    chk("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("write_word", {16'd0, got_q[i]}, {16'd0, exp_q[i]});
    chk("err_flag", {31'd0, o_err}, {31'd0, exp_err});
    chk("busy_idle", {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    start = 1'b0;
    profile = 2'd0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, o_wr_valid}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    chk("rst_word", {16'd0, o_wr_reg, o_wr_data}, 32'd0);
    rstn = 1'b1;

    // Profile 0, ready held high; check first write, delay gap and throughput.
    run_seq(0, 2'd0, 1'b0, 1'b0);
    compare_writes(1'b0);
    if (got_q.size() > 0) chk("first_write", {16'd0, got_q[0]}, 32'h1280);
    if (hs_q.size() >= 3) begin
      // Marker FETCH+DECODE, DLY delay cycles, then FETCH+DECODE+SEND of the next write.
      chk("delay_gap", hs_q[1] - hs_q[0], DLY + 5);
      chk("throughput", hs_q[2] - hs_q[1], 3);
    end else begin
      chk("hs_count", hs_q.size(), 3);
    end

    // Restart after done, with 5-cycle backpressure on every write.
    run_seq(1, 2'd0, 1'b0, 1'b0);
    compare_writes(1'b0);

    // Profile 1, profile toggled and start pulsed throughout (including mid-delay).
    run_seq(2, 2'd1, 1'b1, 1'b1);
    compare_writes(1'b0);

    // Out-of-range profiles.
    run_seq(0, 2'd3, 1'b0, 1'b0);
    compare_writes(1'b1);
    run_seq(2, 2'd2, 1'b0, 1'b0);
    compare_writes(1'b1);

    // Profile 0 with random backpressure and start pulses.
    run_seq(2, 2'd0, 1'b0, 1'b1);
    compare_writes(1'b0);

    // o_done holds with no further writes.
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", {31'd0, o_done}, 32'd1);
    chk("no_extra_writes", got_q.size(), exp_q.size());

    // Reset during SEND.
    ready = 1'b0;
    profile = 2'd0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!o_wr_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_send", {31'd0, o_wr_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_send_valid", {31'd0, o_wr_valid}, 32'd0);
    chk("rst_send_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_send_done", {30'd0, o_done, o_err}, 32'd0);
    chk("rst_send_word", {16'd0, o_wr_reg, o_wr_data}, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    run_seq(2, 2'd0, 1'b0, 1'b0);
    compare_writes(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
